// File: rtl/vga_pkg.sv
// Shared VGA types, cell states and palette for the board renderer.
package vga_pkg;

  localparam int H_W = 11;
  localparam int V_W = 11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_state_t;

  localparam logic [11:0] COLOR_SHIP   = 12'h888;
  localparam logic [11:0] COLOR_HIT    = 12'hF00;
  localparam logic [11:0] COLOR_MISS   = 12'h00F;
  localparam logic [11:0] COLOR_GRID   = 12'h444;
  localparam logic [11:0] COLOR_CURSOR = 12'hFF0;

  // Phase 1 shows HIT cells as SHIP so they appear to blink.
  function automatic logic [11:0] cell_color(
    input cell_state_t s,
    input logic        phase
  );
    logic [11:0] c;
    c = 12'h000;
    unique case (s)
      SHIP:    c = COLOR_SHIP;
      HIT:     c = phase ? COLOR_SHIP : COLOR_HIT;
      MISS:    c = COLOR_MISS;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing plus rgb bundle passed between video stages.
interface vga_if;
  import vga_pkg::*;

  logic [H_W-1:0] hcount;
  logic [V_W-1:0] vcount;
  logic           hsync;
  logic           vsync;
  logic           blank;
  logic [11:0]    rgb;

  modport in (
    input hcount, vcount, hsync, vsync, blank, rgb
  );
  modport out (
    output hcount, vcount, hsync, vsync, blank, rgb
  );
endinterface

// File: rtl/delay.sv
// Fixed-depth shift register used to keep timing aligned with pixel data.
module delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/draw_board.sv
// Overlays game boards, cell colours, grid and cursor on a VGA stream.
// Define DRAW_BOARD_BLINK_EN to make HIT cells blink every BLINK_FRAMES.
module draw_board
  import vga_pkg::*;
#(
  parameter int N_BOARDS     = 2,
  parameter int GRID_N       = 10,
  parameter int CELL_LOG2    = 5,
  parameter int BOARD_X0     = 64,
  parameter int BOARD_Y      = 96,
  parameter int BOARD_PITCH  = 384,
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  vga_if.in    vga_in,
  vga_if.out   vga_out,
  output logic [$clog2(N_BOARDS*GRID_N*GRID_N)-1:0] cell_addr,
  input  cell_state_t cell_state,
  input  logic [(N_BOARDS > 1 ? $clog2(N_BOARDS) : 1)-1:0] cursor_board,
  input  logic [$clog2(GRID_N)-1:0] cursor_col,
  input  logic [$clog2(GRID_N)-1:0] cursor_row
);

  localparam int AW   = $clog2(N_BOARDS*GRID_N*GRID_N);
  localparam int BW   = N_BOARDS > 1 ? $clog2(N_BOARDS) : 1;
  localparam int CW   = $clog2(GRID_N);
  localparam int LW   = CELL_LOG2;
  localparam int SPAN = GRID_N << CELL_LOG2;
  localparam int GG   = GRID_N * GRID_N;
  localparam int FW   = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam int TW   = H_W + V_W + 3;

  logic          hit;
  logic [BW-1:0] brd;
  logic [CW-1:0] col, row;
  logic [LW-1:0] lowx, lowy;
  logic [AW-1:0] addr;
  int            xb, yb;

  // Descending scan so the lowest-indexed overlapping board wins.
  always_comb begin
    hit  = 1'b0;
    brd  = '0;
    col  = '0;
    row  = '0;
    lowx = '0;
    lowy = '0;
    addr = '0;
    xb   = 0;
    yb   = int'(vga_in.vcount) - BOARD_Y;
    for (int b = N_BOARDS - 1; b >= 0; b--) begin
      xb = int'(vga_in.hcount) - (BOARD_X0 + b * BOARD_PITCH);
      if (xb >= 0 && xb < SPAN && yb >= 0 && yb < SPAN) begin
        hit  = 1'b1;
        brd  = BW'(b);
        col  = CW'(xb >> CELL_LOG2);
        row  = CW'(yb >> CELL_LOG2);
        lowx = LW'(xb);
        lowy = LW'(yb);
        addr = AW'(b * GG + (yb >> CELL_LOG2) * GRID_N
                   + (xb >> CELL_LOG2));
      end
    end
  end

  assign cell_addr = hit ? addr : '0;

  logic [TW-1:0] tq;

  delay #(.WIDTH(TW), .DEPTH(2)) u_delay (
    .clk (clk),
    .rst (rst),
    .d   ({vga_in.hcount, vga_in.vcount,
           vga_in.hsync, vga_in.vsync, vga_in.blank}),
    .q   (tq)
  );

  assign {vga_out.hcount, vga_out.vcount,
          vga_out.hsync, vga_out.vsync, vga_out.blank} = tq;

  logic [11:0]   s1_rgb;
  logic          s1_in;
  logic [BW-1:0] s1_brd;
  logic [CW-1:0] s1_col, s1_row;
  logic [LW-1:0] s1_lx, s1_ly;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rgb <= '0;
      s1_in  <= 1'b0;
      s1_brd <= '0;
      s1_col <= '0;
      s1_row <= '0;
      s1_lx  <= '0;
      s1_ly  <= '0;
    end else begin
      s1_rgb <= vga_in.rgb;
      s1_in  <= hit;
      s1_brd <= brd;
      s1_col <= col;
      s1_row <= row;
      s1_lx  <= lowx;
      s1_ly  <= lowy;
    end
  end

  logic [BW-1:0] cur_brd;
  logic [CW-1:0] cur_col, cur_row;
  logic          frame_start;

  assign frame_start = (vga_in.hcount == '0) && (vga_in.vcount == '0);

  // Cursor only moves at frame start so it never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_brd <= '0;
      cur_col <= '0;
      cur_row <= '0;
    end else if (frame_start) begin
      cur_brd <= cursor_board;
      cur_col <= cursor_col;
      cur_row <= cursor_row;
    end
  end

  logic phase;

`ifdef DRAW_BOARD_BLINK_EN
  logic [FW-1:0] frame_cnt;
  logic          vs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      vs_q <= vga_in.vsync;
      if (vga_in.vsync && !vs_q) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign phase = 1'b0;
`endif

  logic        on_cur, rim, grid;
  logic [11:0] pix, rgb_q;

  always_comb begin
    on_cur = s1_in && s1_brd == cur_brd
          && s1_col == cur_col && s1_row == cur_row
          && int'(cur_col) < GRID_N && int'(cur_row) < GRID_N;
    rim  = s1_lx == '0 || s1_lx == '1 || s1_ly == '0 || s1_ly == '1;
    grid = s1_lx == '0 || s1_ly == '0;
    pix  = s1_rgb;
    if (on_cur && rim)
      pix = COLOR_CURSOR;
    else if (s1_in && cell_state != EMPTY)
      pix = cell_color(cell_state, phase);
    else if (s1_in && grid)
      pix = COLOR_GRID;
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= pix;
  end

  assign vga_out.rgb = rgb_q;

endmodule

// File: doc/draw_board.md
DRAW_BOARD -- requirements
Module: draw_board

Interface
REQ-001 Parameter N_BOARDS, default 2: number of game boards drawn (host, guest, ...).
REQ-002 Parameter GRID_N, default 10: cells per board side.
REQ-003 Parameter CELL_LOG2, default 5: cell edge is 2^CELL_LOG2 pixels.
REQ-004 Parameter BOARD_X0, default 64: hcount of board 0 left edge.
REQ-005 Parameter BOARD_Y, default 96: vcount of top edge, shared by all boards.
REQ-006 Parameter BOARD_PITCH, default 384: horizontal offset between consecutive board left edges.
REQ-007 Parameter BLINK_FRAMES, default 30: frames per blink phase.
REQ-008 clk  in  1  pixel clock; one clock; all logic on its rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 vga_in  vga_if.in  -  incoming timing and rgb.
REQ-011 vga_out  vga_if.out  -  outgoing timing and rgb.
REQ-012 cell_addr  out  $clog2(N_BOARDS*GRID_N*GRID_N)  cell-state memory address.
REQ-013 cell_state  in  2  cell_state_t from a synchronous-read memory, valid one clock after cell_addr.
REQ-014 cursor_board  in  $clog2(N_BOARDS) (min 1)  board carrying the cursor.
REQ-015 cursor_col, cursor_row  in  $clog2(GRID_N) each  cursor cell.

Function
REQ-016 cell_addr SHALL be combinational from vga_in: board*GRID_N^2 + row*GRID_N + col, where col and row are the local pixel offsets shifted right by CELL_LOG2; it SHALL be 0 when the pixel is outside every board.
REQ-017 A pixel is inside board b iff BOARD_X0+b*BOARD_PITCH <= hcount < that + GRID_N<<CELL_LOG2, and BOARD_Y <= vcount < BOARD_Y + GRID_N<<CELL_LOG2; edges are exact, with no off-by-one extension.
REQ-018 Stage 1 SHALL register the timing, rgb, inside flag, board index, col/row, and the local low bits; stage 2 SHALL register vga_out, with rgb chosen using cell_state.
REQ-019 Latency from vga_in to vga_out SHALL be exactly 2 clocks for every field; timing fields are unchanged.
REQ-020 Colour priority: cursor outline > cell colour > grid line > pass-through rgb.
REQ-021 Cell colour: EMPTY none; SHIP COLOR_SHIP; HIT COLOR_HIT; MISS COLOR_MISS.
REQ-022 A grid line is drawn in COLOR_GRID where either local low bit-field equals 0, and cell_state is EMPTY.
REQ-023 Cursor outline: pixel in cursor_board/col/row cell with either local low field all-0 or all-1 -> COLOR_CURSOR; cursor_col or cursor_row >= GRID_N draws no cursor.
REQ-024 Cursor inputs SHALL be sampled on the first stage-1 pixel of each frame (vcount=0, hcount=0) so the cursor cannot tear mid-frame.
REQ-025 Pixels outside all boards SHALL pass rgb unchanged.
REQ-026 Overlapping boards (BOARD_PITCH < board width): the lowest board index wins.

Reset
REQ-027 On rst, all vga_out fields, pipeline registers, the sampled cursor, the frame counter, and the blink phase SHALL clear to 0 on the next edge.
REQ-028 Blink phase 0 = HIT shown.
REQ-029 Reset asserted mid-frame SHALL give zero outputs for its duration.
REQ-030 Valid output SHALL resume 2 clocks after deassertion.

Configuration
REQ-031 Macro DRAW_BOARD_BLINK_EN defined: a frame counter SHALL count vga_in.vsync rising edges, wrapping at BLINK_FRAMES-1 and toggling the blink phase on wrap.
REQ-032 With DRAW_BOARD_BLINK_EN defined, HIT cells in phase 1 SHALL render COLOR_SHIP.
REQ-033 Macro absent: there is no counter or phase logic, and HIT always renders COLOR_HIT.

Structure
REQ-034 cell_state_t (EMPTY=0, SHIP=1, HIT=2, MISS=3) and COLOR_SHIP/HIT/MISS/GRID/CURSOR (12-bit) SHALL live in vga_pkg.
REQ-035 The sole sub-module SHALL be the existing delay, used for timing alignment.

Verification (N_BOARDS=2, GRID_N=10, CELL_LOG2=5, BOARD_X0=64, BOARD_Y=96, BOARD_PITCH=384, BLINK_FRAMES=2)
REQ-036 Test: hcount=97, vcount=166, memory returns SHIP.
  -> cell_addr=21 the same cycle.
  -> vga_out.rgb=COLOR_SHIP 2 clocks later.
REQ-037 Test: hcount=448, vcount=96, state EMPTY.
  -> cell_addr=100 and COLOR_GRID.
  -> hcount=447 on the same row passes rgb unchanged.
REQ-038 Test: hcount=10, rgb=12'h123.
  -> vga_out.rgb=12'h123 with all timing fields equal to the input 2 clocks earlier.
REQ-039 Test: cursor board0 col0 row0, state SHIP.
  -> pixel (64,96) gives COLOR_CURSOR.
  -> pixel (80,112) gives COLOR_SHIP.
  -> cursor_col=10 yields no cursor.
REQ-040 Test: BLINK_EN defined, HIT cell, 4 vsync rising edges.
  -> pattern COLOR_HIT for 2 frames, COLOR_SHIP for 2 frames, then COLOR_HIT again.
  -> macro undefined: always COLOR_HIT.
REQ-041 Test: rst pulsed at vcount=200.
  -> vga_out all zero next edge.
  -> correct output 2 clocks after release.
  -> frame counter restarts from 0.
